control_unit_seq: RTL and testbench

Sequenced, parametrised control unit for the 9-bit ISA. It accepts one instruction per valid/ready handshake and drives registered datapath controls. It adds a latched compare-flag register with same-cycle bypass, a multi-cycle memory req/ack handshake with timeout, and a nibble-preserving LUT immediate register. It sits between instruction fetch and the register file, ALU, shifter and data memory.

---
 rtl/cu_pkg.sv | 74 +++++++
 rtl/control_unit_seq_if.sv | 15 +
 rtl/cu_mem_timer.sv | 33 +++
 rtl/control_unit_seq.sv | 219 +++++++++++++++++++++
 tb/tb_control_unit_seq.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared types for the sequenced 9-bit ISA control unit: instruction classes,
// sub-opcodes, write-back encodings, FSM states and the registered control bundle.
package cu_pkg;

    typedef enum logic [1:0] {
        T_R = 2'b00,
        T_M = 2'b01,
        T_B = 2'b10,
        T_S = 2'b11
    } instr_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MEM  = 2'b01,
        S_WB   = 2'b10
    } state_e;

    localparam logic [2:0] R_SLT     = 3'b101;

    localparam logic [2:0] M_ST      = 3'b000;
    localparam logic [2:0] M_LD      = 3'b001;
    localparam logic [2:0] M_LUTW_LO = 3'b010;
    localparam logic [2:0] M_LUTW_HI = 3'b011;
    localparam logic [2:0] M_LUT_LO  = 3'b100;
    localparam logic [2:0] M_LUT_HI  = 3'b101;
    localparam logic [2:0] M_LUT_RD  = 3'b110;
    localparam logic [2:0] M_ILL     = 3'b111;

    localparam logic [1:0] B_EQ  = 2'b00;
    localparam logic [1:0] B_LT  = 2'b01;
    localparam logic [1:0] B_LTE = 2'b10;
    localparam logic [1:0] B_UN  = 2'b11;

    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_LUT   = 2'd2;
    localparam logic [1:0] WB_SHIFT = 2'd3;

    localparam int BR_IDX_MAX = 5;

    typedef struct packed {
        logic                  instr_ready;
        logic                  mem_req;
        logic                  mem_we;
        logic                  mem_err;
        logic [2:0]            alu_op;
        logic [1:0]            r_addr1;
        logic [1:0]            r_addr2;
        logic                  reg_we;
        logic [1:0]            wb_sel;
        logic                  cmp_en;
        logic                  branch_en;
        logic [BR_IDX_MAX-1:0] branch_idx;
        logic                  shift_en;
        logic                  shift_dir;
        logic                  shift_imm_en;
        logic [7:0]            shift_imm;
        logic [7:0]            lut_idx;
        logic                  lut_we;
        logic [1:0]            lut_rd_dst;
        logic                  illegal;
    } ctrl_t;

    function automatic logic branch_taken(input logic [1:0] cond, input logic eq, input logic lt);
        case (cond)
            B_EQ:    return eq;
            B_LT:    return lt;
            B_LTE:   return lt | eq;
            B_UN:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_seq_if.sv
// Instruction handshake and data-memory request bus of the control unit.
interface control_unit_seq_if;
    logic       instr_valid;
    logic       instr_ready;
    logic [8:0] instr;
    logic       mem_req;
    logic       mem_we;
    logic       mem_ack;
    logic       mem_err;

    modport master (output instr_valid, instr, mem_ack,
                    input  instr_ready, mem_req, mem_we, mem_err);
    modport slave  (input  instr_valid, instr, mem_ack,
                    output instr_ready, mem_req, mem_we, mem_err);
endinterface

// File: rtl/cu_mem_timer.sv
// Wait-cycle counter for an outstanding memory request; an ack in the
// final allowed cycle takes precedence over the timeout.
module cu_mem_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ack,
    output logic done,
    output logic timeout
);
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    logic [CW-1:0] cnt_r;

    // Count unacknowledged request cycles; idle or ack returns to zero so entry starts clean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (!active || ack) begin
            cnt_r <= '0;
        end else if (cnt_r != LAST) begin
            cnt_r <= cnt_r + CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done    = active & ack;
    assign timeout = (MEM_TIMEOUT > 0) && active && !ack && (cnt_r == LAST);
endmodule

// File: rtl/control_unit_seq.sv
// Sequenced control unit: decodes one instruction per handshake into registered
// datapath controls, with flag bypass, memory wait/timeout and LUT immediate register.
module control_unit_seq
    import cu_pkg::*;
#(
    parameter int BR_IDX_W      = 5,
    parameter int MEM_TIMEOUT   = 15,
    parameter int STRICT_DECODE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    control_unit_seq_if.slave   bus,
    input  logic                equal_in,
    input  logic                less_in,
    output logic [2:0]          alu_op,
    output logic [1:0]          r_addr1,
    output logic [1:0]          r_addr2,
    output logic                reg_we,
    output logic [1:0]          wb_sel,
    output logic                cmp_en,
    output logic                flag_eq,
    output logic                flag_lt,
    output logic                branch_en,
    output logic [BR_IDX_W-1:0] branch_idx,
    output logic                shift_en,
    output logic                shift_dir,
    output logic                shift_imm_en,
    output logic [7:0]          shift_imm,
    output logic [7:0]          lut_reg,
    output logic [7:0]          lut_idx,
    output logic                lut_we,
    output logic [1:0]          lut_rd_dst,
    output logic                illegal
);
    state_e      state_r, state_s;
    ctrl_t       ctrl_r, ctrl_s;
    logic [7:0]  lut_reg_r, lut_reg_s;
    logic        flag_eq_r, flag_lt_r;
    instr_type_e itype_s;
    logic [2:0]  sub_s;
    logic [3:0]  nib_s;
    logic        accept_s, eq_src_s, lt_src_s, mem_done_s, mem_timeout_s;

    assign itype_s  = instr_type_e'(bus.instr[8:7]);
    assign sub_s    = bus.instr[6:4];
    assign nib_s    = bus.instr[3:0];
    assign accept_s = ctrl_r.instr_ready & bus.instr_valid;
    // A compare issuing this cycle has not reached the flag register yet
    assign eq_src_s = ctrl_r.cmp_en ? equal_in : flag_eq_r;
    assign lt_src_s = ctrl_r.cmp_en ? less_in  : flag_lt_r;

    cu_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (state_r == S_MEM),
        .ack     (bus.mem_ack),
        .done    (mem_done_s),
        .timeout (mem_timeout_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, next-cycle controls and next LUT register value
    always_comb begin
        state_s   = state_r;
        ctrl_s    = '0;
        lut_reg_s = lut_reg_r;
        case (state_r)
            S_IDLE: begin
                ctrl_s.instr_ready = 1'b1;
                if (accept_s) begin
                    case (itype_s)
                        T_R: begin
                            ctrl_s.alu_op  = sub_s;
                            ctrl_s.r_addr1 = bus.instr[3:2];
                            ctrl_s.r_addr2 = bus.instr[1:0];
                            if (sub_s >= R_SLT) begin
                                ctrl_s.cmp_en = 1'b1;
                            end else begin
                                ctrl_s.reg_we = 1'b1;
                                ctrl_s.wb_sel = WB_ALU;
                            end
                        end
                        T_B: begin
                            if (branch_taken(bus.instr[6:5], eq_src_s, lt_src_s)) begin
                                ctrl_s.branch_en  = 1'b1;
                                ctrl_s.branch_idx = BR_IDX_MAX'(bus.instr[BR_IDX_W-1:0]);
                            end else begin
                                ctrl_s.branch_en  = 1'b0;
                            end
                        end
                        T_S: begin
                            ctrl_s.shift_en  = 1'b1;
                            ctrl_s.shift_dir = bus.instr[5];
                            ctrl_s.reg_we    = 1'b1;
                            ctrl_s.wb_sel    = WB_SHIFT;
                            if (bus.instr[6]) begin
                                ctrl_s.shift_imm_en = 1'b1;
                                ctrl_s.shift_imm    = {3'b000, bus.instr[4:0]};
                            end else begin
                                ctrl_s.shift_imm_en = 1'b0;
                            end
                        end
                        T_M: begin
                            case (sub_s)
                                M_ST, M_LD: begin
                                    state_s            = S_MEM;
                                    ctrl_s.instr_ready = 1'b0;
                                    ctrl_s.mem_req     = 1'b1;
                                    ctrl_s.mem_we      = (sub_s == M_ST);
                                end
                                M_LUTW_LO: begin
                                    ctrl_s.lut_we  = 1'b1;
                                    ctrl_s.lut_idx = {4'h0, nib_s};
                                end
                                M_LUTW_HI: begin
                                    ctrl_s.lut_we  = 1'b1;
                                    ctrl_s.lut_idx = {nib_s, 4'h0};
                                end
                                M_LUT_LO: lut_reg_s = {lut_reg_r[7:4], nib_s};
                                M_LUT_HI: lut_reg_s = {nib_s, lut_reg_r[3:0]};
                                M_LUT_RD: begin
                                    ctrl_s.reg_we     = 1'b1;
                                    ctrl_s.wb_sel     = WB_LUT;
                                    ctrl_s.lut_rd_dst = bus.instr[3:2];
                                end
                                M_ILL:   ctrl_s.illegal = (STRICT_DECODE != 0);
                                default: ctrl_s.illegal = 1'b0;
                            endcase
                        end
                        default: ctrl_s.illegal = 1'b0;
                    endcase
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_MEM: begin
                if (mem_done_s) begin
                    if (ctrl_r.mem_we) begin
                        state_s            = S_IDLE;
                        ctrl_s.instr_ready = 1'b1;
                    end else begin
                        state_s       = S_WB;
                        ctrl_s.reg_we = 1'b1;
                        ctrl_s.wb_sel = WB_MEM;
                    end
                end else if (mem_timeout_s) begin
                    state_s            = S_IDLE;
                    ctrl_s.instr_ready = 1'b1;
                    ctrl_s.mem_err     = 1'b1;
                end else begin
                    ctrl_s.mem_req = 1'b1;
                    ctrl_s.mem_we  = ctrl_r.mem_we;
                end
            end
            S_WB: begin
                state_s            = S_IDLE;
                ctrl_s.instr_ready = 1'b1;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Registered control outputs and LUT immediate register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r    <= '0;
            lut_reg_r <= 8'h00;
        end else begin
            ctrl_r    <= ctrl_s;
            lut_reg_r <= lut_reg_s;
        end
    end

    // Compare flags latch the live ALU result at the end of a compare cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_eq_r <= 1'b0;
            flag_lt_r <= 1'b0;
        end else if (ctrl_r.cmp_en) begin
            flag_eq_r <= equal_in;
            flag_lt_r <= less_in;
        end else begin
            flag_eq_r <= flag_eq_r;
            flag_lt_r <= flag_lt_r;
        end
    end

    assign bus.instr_ready = ctrl_r.instr_ready;
    assign bus.mem_req     = ctrl_r.mem_req;
    assign bus.mem_we      = ctrl_r.mem_we;
    assign bus.mem_err     = ctrl_r.mem_err;
    assign alu_op          = ctrl_r.alu_op;
    assign r_addr1         = ctrl_r.r_addr1;
    assign r_addr2         = ctrl_r.r_addr2;
    assign reg_we          = ctrl_r.reg_we;
    assign wb_sel          = ctrl_r.wb_sel;
    assign cmp_en          = ctrl_r.cmp_en;
    assign flag_eq         = flag_eq_r;
    assign flag_lt         = flag_lt_r;
    assign branch_en       = ctrl_r.branch_en;
    assign branch_idx      = ctrl_r.branch_idx[BR_IDX_W-1:0];
    assign shift_en        = ctrl_r.shift_en;
    assign shift_dir       = ctrl_r.shift_dir;
    assign shift_imm_en    = ctrl_r.shift_imm_en;
    assign shift_imm       = ctrl_r.shift_imm;
    assign lut_reg         = lut_reg_r;
    assign lut_idx         = ctrl_r.lut_idx;
    assign lut_we          = ctrl_r.lut_we;
    assign lut_rd_dst      = ctrl_r.lut_rd_dst;
    assign illegal         = ctrl_r.illegal;
endmodule

// File: tb/tb_control_unit_seq.sv
// Directed bench for control_unit_seq: hand-computed expectations checked one cycle
// after each accept, plus memory wait, timeout and reset-abort sequences.
module tb_control_unit_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       equal_in, less_in;
    logic [2:0] alu_op;
    logic [1:0] r_addr1, r_addr2, wb_sel, lut_rd_dst;
    logic       reg_we, cmp_en, flag_eq, flag_lt, branch_en;
    logic [4:0] branch_idx;
    logic       shift_en, shift_dir, shift_imm_en, lut_we, illegal;
    logic [7:0] shift_imm, lut_reg, lut_idx;
    int         checks = 0;
    int         errors = 0;

    control_unit_seq_if bus ();

    control_unit_seq #(.BR_IDX_W(5), .MEM_TIMEOUT(15), .STRICT_DECODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .equal_in(equal_in), .less_in(less_in),
        .alu_op(alu_op), .r_addr1(r_addr1), .r_addr2(r_addr2),
        .reg_we(reg_we), .wb_sel(wb_sel), .cmp_en(cmp_en),
        .flag_eq(flag_eq), .flag_lt(flag_lt),
        .branch_en(branch_en), .branch_idx(branch_idx),
        .shift_en(shift_en), .shift_dir(shift_dir), .shift_imm_en(shift_imm_en),
        .shift_imm(shift_imm), .lut_reg(lut_reg), .lut_idx(lut_idx),
        .lut_we(lut_we), .lut_rd_dst(lut_rd_dst), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [8:0] word);
        bus.instr_valid = 1'b1;
        bus.instr       = word;
        tick();
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        equal_in        = 1'b0;
        less_in         = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 9'h000;
        bus.mem_ack     = 1'b0;
        #2;
        chk("rst_ready",   32'(bus.instr_ready), 32'h0);
        chk("rst_mem_req", 32'(bus.mem_req),     32'h0);
        chk("rst_lut_reg", 32'(lut_reg),         32'h0);
        chk("rst_flag_eq", 32'(flag_eq),         32'h0);
        chk("rst_reg_we",  32'(reg_we),          32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 32'(bus.instr_ready), 32'h1);

        // ADD r1,r2
        issue(9'h036);
        chk("add_alu_op", 32'(alu_op),          32'h3);
        chk("add_ra1",    32'(r_addr1),         32'h1);
        chk("add_ra2",    32'(r_addr2),         32'h2);
        chk("add_reg_we", 32'(reg_we),          32'h1);
        chk("add_wb_sel", 32'(wb_sel),          32'h0);
        chk("add_ready",  32'(bus.instr_ready), 32'h1);
        tick();
        chk("add_one_cycle", 32'(reg_we), 32'h0);

        // EQ with live equal, then BEQ 5 resolved through the bypass
        equal_in = 1'b1;
        issue(9'h071);
        chk("eq_cmp_en", 32'(cmp_en),  32'h1);
        chk("eq_no_we",  32'(reg_we),  32'h0);
        chk("eq_flag0",  32'(flag_eq), 32'h0);
        issue(9'h105);
        equal_in = 1'b0;
        chk("beq_byp_en",  32'(branch_en),  32'h1);
        chk("beq_byp_idx", 32'(branch_idx), 32'h5);
        chk("flag_eq_set", 32'(flag_eq),    32'h1);
        issue(9'h105);
        chk("beq_flag_en",  32'(branch_en),  32'h1);
        chk("beq_flag_idx", 32'(branch_idx), 32'h5);
        issue(9'h125);
        chk("blt_nt_en",  32'(branch_en),  32'h0);
        chk("blt_nt_idx", 32'(branch_idx), 32'h0);
        issue(9'h17F);
        chk("bun_en",  32'(branch_en),  32'h1);
        chk("bun_idx", 32'(branch_idx), 32'h1F);

        // SLT with live less, then BLTE through the bypass
        less_in = 1'b1;
        issue(9'h050);
        chk("slt_alu_op", 32'(alu_op), 32'h5);
        chk("slt_cmp_en", 32'(cmp_en), 32'h1);
        issue(9'h145);
        less_in = 1'b0;
        chk("blte_en",     32'(branch_en), 32'h1);
        chk("slt_flag_lt", 32'(flag_lt),   32'h1);
        chk("slt_flag_eq", 32'(flag_eq),   32'h0);

        // LUT immediate register, LUT write index, LUT read
        issue(9'h0CA);
        chk("lut_lo", 32'(lut_reg), 32'h0A);
        issue(9'h0D3);
        chk("lut_hi", 32'(lut_reg), 32'h3A);
        issue(9'h0A5);
        chk("lutw_lo_we",  32'(lut_we),  32'h1);
        chk("lutw_lo_idx", 32'(lut_idx), 32'h05);
        issue(9'h0B5);
        chk("lutw_hi_idx", 32'(lut_idx), 32'h50);
        issue(9'h0EC);
        chk("lutrd_we",  32'(reg_we),     32'h1);
        chk("lutrd_wb",  32'(wb_sel),     32'h2);
        chk("lutrd_dst", 32'(lut_rd_dst), 32'h3);
        chk("lutrd_lwe", 32'(lut_we),     32'h0);

        // Shifts: LSI #0x15, then LSR
        issue(9'h1D5);
        chk("lsi_en",  32'(shift_en),     32'h1);
        chk("lsi_dir", 32'(shift_dir),    32'h0);
        chk("lsi_ien", 32'(shift_imm_en), 32'h1);
        chk("lsi_imm", 32'(shift_imm),    32'h15);
        chk("lsi_wb",  32'(wb_sel),       32'h3);
        issue(9'h1A0);
        chk("lsr_dir", 32'(shift_dir),    32'h1);
        chk("lsr_ien", 32'(shift_imm_en), 32'h0);
        chk("lsr_we",  32'(reg_we),       32'h1);

        // Undefined M 111
        issue(9'h0F0);
        chk("ill_pulse",  32'(illegal),     32'h1);
        chk("ill_reg_we", 32'(reg_we),      32'h0);
        chk("ill_lut_we", 32'(lut_we),      32'h0);
        chk("ill_memreq", 32'(bus.mem_req), 32'h0);
        tick();
        chk("ill_one_cycle", 32'(illegal), 32'h0);

        // LB with ack in the third request cycle
        issue(9'h09B);
        chk("lb_req1",   32'(bus.mem_req),     32'h1);
        chk("lb_we",     32'(bus.mem_we),      32'h0);
        chk("lb_ready1", 32'(bus.instr_ready), 32'h0);
        tick();
        chk("lb_req2", 32'(bus.mem_req), 32'h1);
        tick();
        chk("lb_req3",   32'(bus.mem_req),     32'h1);
        chk("lb_ready3", 32'(bus.instr_ready), 32'h0);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("lb_req_drop", 32'(bus.mem_req),     32'h0);
        chk("lb_wb_we",    32'(reg_we),          32'h1);
        chk("lb_wb_sel",   32'(wb_sel),          32'h1);
        chk("lb_wb_ready", 32'(bus.instr_ready), 32'h0);
        tick();
        chk("lb_done_we",    32'(reg_we),          32'h0);
        chk("lb_done_ready", 32'(bus.instr_ready), 32'h1);

        // Store with no ack: 15 request cycles then timeout
        issue(9'h080);
        for (int i = 0; i < 15; i++) begin
            chk("st_to_req", 32'(bus.mem_req), 32'h1);
            chk("st_to_we",  32'(bus.mem_we),  32'h1);
            chk("st_to_err", 32'(bus.mem_err), 32'h0);
            tick();
        end
        chk("st_to_req_drop", 32'(bus.mem_req),     32'h0);
        chk("st_to_err_on",   32'(bus.mem_err),     32'h1);
        chk("st_to_no_we",    32'(reg_we),          32'h0);
        chk("st_to_ready",    32'(bus.instr_ready), 32'h1);
        tick();
        chk("st_to_err_once", 32'(bus.mem_err), 32'h0);

        // Store with ack in the 15th cycle: ack wins over timeout
        issue(9'h080);
        for (int i = 0; i < 14; i++) begin
            chk("st_ack_req", 32'(bus.mem_req), 32'h1);
            tick();
        end
        chk("st_ack_req15", 32'(bus.mem_req), 32'h1);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("st_ack_no_err", 32'(bus.mem_err),     32'h0);
        chk("st_ack_req0",   32'(bus.mem_req),     32'h0);
        chk("st_ack_ready",  32'(bus.instr_ready), 32'h1);
        chk("st_ack_no_we",  32'(reg_we),          32'h0);

        // Reset asserted mid-request drops mem_req without a clock edge
        issue(9'h09B);
        chk("rstm_req_on", 32'(bus.mem_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstm_req_off", 32'(bus.mem_req),     32'h0);
        chk("rstm_ready",   32'(bus.instr_ready), 32'h0);
        chk("rstm_lut_reg", 32'(lut_reg),         32'h0);
        chk("rstm_flag_lt", 32'(flag_lt),         32'h0);
        tick();
        chk("rstm_no_wb", 32'(reg_we), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rstm_ready_back", 32'(bus.instr_ready), 32'h1);
        chk("rstm_req_stays",  32'(bus.mem_req),     32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
